// File: rtl/sonar_echo_ranger.sv
// Ultrasonic ranging controller: fires the trigger pulse and times the echo
// in whole microseconds using a state-local prescaler.
module sonar_echo_ranger #(
  parameter int CLKS_PER_US = 50,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 38000,
  parameter int COOLDOWN_US = 60000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        echo,
  output logic        trig,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        valid,
  output logic [31:0] echo_us
);

  localparam int UMAX = (TIMEOUT_US > COOLDOWN_US) ? TIMEOUT_US : COOLDOWN_US;
  localparam int UW   = $clog2(UMAX + 1);
  localparam int PW   = $clog2(CLKS_PER_US);

  localparam logic [PW-1:0] PS_LAST = PW'(CLKS_PER_US - 1);
  localparam logic [PW-1:0] PS_MEAS = PW'(1);
  localparam logic [UW-1:0] TRIG_LAST = UW'(TRIG_US - 1);
  localparam logic [UW-1:0] TO_LAST   = UW'(TIMEOUT_US - 1);
  localparam logic [UW-1:0] CD_LAST   = UW'(COOLDOWN_US - 1);
  localparam logic [UW-1:0] U_SAT     = UW'(UMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_COOL
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] ps;
  logic [UW-1:0] us_cnt;
  logic          echo_m, echo_s, echo_p;
  logic          tick, rise;
  logic          load;
  logic [31:0]   load_us;
  logic          load_to;

  assign tick = (ps == PS_LAST);
  assign rise = echo_s & ~echo_p;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
      echo_p <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_p <= echo_s;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    load_us = '0;
    load_to = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_TRIG;
      end
      S_TRIG: begin
        if (tick && us_cnt == TRIG_LAST) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (tick && us_cnt == TO_LAST) begin
          load    = 1'b1;
          load_to = 1'b1;
          state_n = S_COOL;
        end else if (rise) begin
          state_n = S_MEAS;
        end
      end
      S_MEAS: begin
        if (!echo_s) begin
          load    = 1'b1;
          load_us = (tick && us_cnt == TO_LAST)
                  ? 32'(TIMEOUT_US) : 32'(us_cnt);
          state_n = S_COOL;
        end else if (tick && us_cnt == TO_LAST) begin
          load    = 1'b1;
          load_us = 32'(TIMEOUT_US);
          load_to = 1'b1;
          state_n = S_COOL;
        end
      end
      S_COOL: begin
        if (tick && us_cnt == CD_LAST) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The rise cycle itself is already echo-high time, so MEASURE starts
  // one prescaler step in to keep the width exact.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      ps     <= '0;
      us_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || state == S_IDLE) begin
        ps     <= (state_n == S_MEAS) ? PS_MEAS : '0;
        us_cnt <= '0;
      end else if (tick) begin
        ps <= '0;
        if (us_cnt != U_SAT) us_cnt <= us_cnt + 1'b1;
      end else begin
        ps <= ps + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      trig    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      valid   <= 1'b0;
      echo_us <= '0;
    end else begin
      trig <= (state_n == S_TRIG);
      busy <= (state_n != S_IDLE);
      done <= load;
      if (load) begin
        echo_us <= load_us;
        timeout <= load_to;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sonar_echo_ranger.sv
// Bench for sonar_echo_ranger: scheduled echo scenarios against a
// timing/result model derived from the ranging rules.
module tb_sonar_echo_ranger;

  localparam int C  = 4;
  localparam int TU = 2;
  localparam int TO = 20;
  localparam int CD = 5;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        echo = 1'b0;
  logic        trig, busy, done, timeout, valid;
  logic [31:0] echo_us;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  int trig_lo = 0, trig_hi = -1;
  int busy_lo = 0, busy_hi = -1;
  int done_cyc = -1;
  int pend_us = 0, pend_to = 0;
  int exp_us = 0, exp_to = 0, exp_valid = 0;
  int trig_cnt = 0, done_cnt = 0, last_done = -1;

  sonar_echo_ranger #(
    .CLKS_PER_US(C),
    .TRIG_US(TU),
    .TIMEOUT_US(TO),
    .COOLDOWN_US(CD)
  ) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .echo(echo),
    .trig(trig),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .valid(valid),
    .echo_us(echo_us)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run && !clr) begin
      if (cyc == done_cyc) begin
        exp_us    = pend_us;
        exp_to    = pend_to;
        exp_valid = 1;
      end
      chk("trig", int'(trig), int'(cyc >= trig_lo && cyc <= trig_hi));
      chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      chk("done", int'(done), int'(cyc == done_cyc));
      chk("echo_us", int'(echo_us), exp_us);
      chk("timeout", int'(timeout), exp_to);
      chk("valid", int'(valid), exp_valid);
      if (trig) trig_cnt++;
      if (done) begin
        done_cnt++;
        last_done = cyc;
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0: echo pulse of n cycles whose synced rise lands off cycles
  // into WAIT_RISE; kind 1: no echo; kind 2: echo high before trig ends.
  task automatic do_meas(input int kind, input int n, input int off,
                         input bit mask, output int d, output int w);
    int p, e;
    p = cyc;
    e = 0;
    w = p + 1 + TU * C;
    start = 1'b1;
    trig_lo = p + 1;
    trig_hi = p + TU * C;
    if (kind == 0) begin
      e = w + off - 2;
      if (n >= TO * C) begin
        d = e + 2 + TO * C;
        pend_us = TO;
        pend_to = 1;
      end else begin
        d = e + n + 3;
        pend_us = (n == TO * C - 1) ? TO : n / C;
        pend_to = 0;
      end
    end else begin
      e = p + 3;
      d = w + TO * C;
      pend_us = 0;
      pend_to = 1;
    end
    done_cyc = d;
    busy_lo = p + 1;
    busy_hi = d + CD * C - 1;
    wait_to(p + 1);
    start = 1'b0;
    if (mask) begin
      wait_to(p + 3);
      start = 1'b1;
      wait_to(p + 4);
      start = 1'b0;
    end
    if (kind == 0) begin
      wait_to(e);
      echo = 1'b1;
      if (mask) begin
        wait_to(e + 5);
        start = 1'b1;
        wait_to(e + 6);
        start = 1'b0;
      end
      wait_to(e + n);
      echo = 1'b0;
    end else if (kind == 2) begin
      wait_to(e);
      echo = 1'b1;
      wait_to(d + 2);
      echo = 1'b0;
    end else begin
      wait_to(d + 3);
      echo = 1'b1;
      wait_to(d + 6);
      echo = 1'b0;
    end
    if (mask) begin
      wait_to(d + 5);
      start = 1'b1;
      wait_to(d + 6);
      start = 1'b0;
    end
    wait_to(d + CD * C);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, w, t0, c0, kind, n, off;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_echo_us", int'(echo_us), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    run = 1'b1;

    t0 = trig_cnt;
    c0 = done_cnt;
    do_meas(0, 40, 12, 1'b0, d, w);
    chk("s1_trig_len", trig_cnt - t0, 8);
    chk("s1_done_cnt", done_cnt - c0, 1);
    chk("s1_echo_us", int'(echo_us), 10);
    chk("s1_timeout", int'(timeout), 0);
    chk("s1_valid", int'(valid), 1);
    chk("s1_busy_gap", cyc - last_done, 20);
    chk("s1_busy_low", int'(busy), 0);

    do_meas(0, 43, 5, 1'b0, d, w);
    chk("s2_w43", int'(echo_us), 10);
    do_meas(0, 44, 0, 1'b0, d, w);
    chk("s2_w44", int'(echo_us), 11);

    do_meas(0, 79, 7, 1'b0, d, w);
    chk("tie_us", int'(echo_us), 20);
    chk("tie_to", int'(timeout), 0);
    do_meas(0, 80, 2, 1'b0, d, w);
    chk("w80_us", int'(echo_us), 20);
    chk("w80_to", int'(timeout), 1);

    do_meas(1, 0, 0, 1'b0, d, w);
    chk("s3_delay", last_done - w, 80);
    chk("s3_us", int'(echo_us), 0);
    chk("s3_to", int'(timeout), 1);

    do_meas(0, 30, 3, 1'b0, d, w);
    do_meas(2, 0, 0, 1'b0, d, w);
    chk("s4a_us", int'(echo_us), 0);
    chk("s4a_to", int'(timeout), 1);
    do_meas(0, 200, 6, 1'b0, d, w);
    chk("s4b_us", int'(echo_us), 20);
    chk("s4b_to", int'(timeout), 1);

    t0 = trig_cnt;
    c0 = done_cnt;
    do_meas(0, 40, 8, 1'b1, d, w);
    chk("s5_done_cnt", done_cnt - c0, 1);
    chk("s5_trig_len", trig_cnt - t0, 8);
    chk("s5_us", int'(echo_us), 10);
    do_meas(0, 20, 3, 1'b0, d, w);
    chk("s5_next_us", int'(echo_us), 5);

    begin
      int p;
      p = cyc;
      start = 1'b1;
      trig_lo = p + 1;
      trig_hi = p + TU * C;
      busy_lo = p + 1;
      busy_hi = p + 1000;
      done_cyc = -1;
      wait_to(p + 1);
      start = 1'b0;
      wait_to(p + 3);
      #1;
      clr = 1'b1;
      trig_hi = -1;
      busy_hi = -1;
      exp_us = 0;
      exp_to = 0;
      exp_valid = 0;
      #1;
      chk("s6_trig", int'(trig), 0);
      chk("s6_busy", int'(busy), 0);
      chk("s6_valid", int'(valid), 0);
      chk("s6_echo_us", int'(echo_us), 0);
      wait_to(p + 5);
      clr = 1'b0;
    end
    t0 = trig_cnt;
    do_meas(0, 40, 4, 1'b0, d, w);
    chk("s6_trig_len", trig_cnt - t0, 8);
    chk("s6_us", int'(echo_us), 10);
    chk("s6_valid_after", int'(valid), 1);

    for (int i = 0; i < 14; i++) begin
      kind = ($urandom_range(0, 7) == 0) ? 1 : 0;
      n = $urandom_range(1, 120);
      off = $urandom_range(0, 60);
      do_meas(kind, n, off, 1'b0, d, w);
      chk("rnd_us", int'(echo_us), pend_us);
      chk("rnd_to", int'(timeout), pend_to);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
